// File: rtl/filter_pkg.sv
// Shared types for the IIR filter path: sample format, DAC transmitter states and the
// sign-magnitude to offset-binary conversion also used by the ADC receiver.
package filter_pkg;

    localparam int FILT_N   = 15;
    localparam int SIGN_BIT = FILT_N;

    typedef logic [FILT_N:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    // Negative zero maps to mid-scale; mag < 2^N keeps the result inside W bits.
    function automatic sample_t sm_to_offset_bin(input sample_t s);
        sample_t mid;
        sample_t mag;
        mid = sample_t'(1) << SIGN_BIT;
        mag = {1'b0, s[SIGN_BIT-1:0]};
        return s[SIGN_BIT] ? (mid - mag) : (mid + mag);
    endfunction

endpackage

// File: rtl/dac_serial_tx_sclk_gen.sv
// Serial clock generator: divides clk by 2*CLK_DIV while enabled, idles low otherwise,
// and flags the cycle in which sclk is about to rise or fall.
module dac_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic          wrap;

    assign wrap = en && (div == DW'(CLK_DIV - 1));
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            div  <= '0;
            sclk <= ~sclk;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/dac_serial_tx.sv
// SPI mode-0 write-only transmitter feeding filter output samples to a serial DAC, MSB first.
// Define DAC_TX_OFFSET_BIN_EN to send offset binary instead of sign-magnitude (timing unchanged).
module dac_serial_tx #(
    parameter int N       = 15,
    parameter int CLK_DIV = 2,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [N:0] sample_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       sdo_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int W  = N + 1;
    localparam int BW = $clog2(W + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] ST_IDLE  = filter_pkg::IDLE;
    localparam logic [1:0] ST_SHIFT = filter_pkg::SHIFT;
    localparam logic [1:0] ST_GAP   = filter_pkg::GAP;

    logic [1:0]    state;
    logic [N:0]    sreg;
    logic [N:0]    word_in;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          sclk_en;
    logic          sclk_rise;
    logic          sclk_fall;

`ifdef DAC_TX_OFFSET_BIN_EN
    if (N == filter_pkg::FILT_N) begin : g_ob_pkg
        assign word_in = filter_pkg::sm_to_offset_bin(sample_i);
    end else begin : g_ob_generic
        localparam logic [N:0] MID = {1'b1, {N{1'b0}}};
        logic [N:0] mag;
        assign mag     = {1'b0, sample_i[N-1:0]};
        assign word_in = sample_i[N] ? (MID - mag) : (MID + mag);
    end
`else
    assign word_in = sample_i;
`endif

    assign sclk_en = (state == ST_SHIFT);

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (sclk_en),
        .sclk (sclk_o),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready_o <= 1'b1;
            cs_n_o  <= 1'b1;
            sdo_o   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sreg    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_i && ready_o) begin
                        sreg    <= word_in;
                        sdo_o   <= word_in[N];
                        cs_n_o  <= 1'b0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise)
                        bit_cnt <= bit_cnt + 1'b1;
                    // The falling edge after the last rising edge closes the frame.
                    if (sclk_fall) begin
                        if (bit_cnt == BW'(W)) begin
                            cs_n_o  <= 1'b1;
                            sdo_o   <= 1'b0;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            sreg  <= {sreg[N-1:0], 1'b0};
                            sdo_o <= sreg[N-1];
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        done_o  <= 1'b1;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Randomised bench for dac_serial_tx: a cycle-offset model of each frame checks every output
// each cycle, and a DAC-side capture checks the shifted words against the accepted ones.
module tb_dac_serial_tx;

    localparam int N       = 15;
    localparam int W       = 16;
    localparam int CLK_DIV = 2;
    localparam int GAP     = 2;
    localparam int FRAME   = 2 * CLK_DIV * W;
    localparam int DONE_D  = 1 + FRAME + GAP;

`ifdef DAC_TX_OFFSET_BIN_EN
    localparam logic [15:0] E_028B = 16'h828B, E_80D2 = 16'h7F2E, E_8000 = 16'h8000;
    localparam logic [15:0] E_02A3 = 16'h82A3, E_1234 = 16'h9234, E_0F0F = 16'h8F0F;
`else
    localparam logic [15:0] E_028B = 16'h028B, E_80D2 = 16'h80D2, E_8000 = 16'h8000;
    localparam logic [15:0] E_02A3 = 16'h02A3, E_1234 = 16'h1234, E_0F0F = 16'h0F0F;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic [N:0] sample_i = '0;
    logic       ready_o, sclk_o, cs_n_o, sdo_o, busy_o, done_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dac_serial_tx #(.N(N), .CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .sample_i (sample_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sclk_o   (sclk_o),
        .cs_n_o   (cs_n_o),
        .sdo_o    (sdo_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [15:0] s);
`ifdef DAC_TX_OFFSET_BIN_EN
        int r;
        r = s[15] ? 32768 - int'(s[14:0]) : 32768 + int'(s[14:0]);
        return r[15:0];
`else
        return s;
`endif
    endfunction

    // Model: a frame is described only by its start cycle and word; outputs follow from the offset.
    int          cyc = 0;
    int          m_t0 = 0;
    int          n_acc = 0;
    bit          m_frame = 1'b0;
    bit          started = 1'b0;
    bit          rst_seen = 1'b0;
    logic [15:0] m_word = '0;
    logic [15:0] exp_q[$];

    function automatic bit m_idle();
        return !m_frame || (cyc - m_t0 + 1 >= DONE_D);
    endfunction

    always @(posedge clk) begin
        rst_seen <= rst;
        started  <= 1'b1;
        if (rst) begin
            m_frame <= 1'b0;
            exp_q.delete();
        end else if (valid_i && m_idle()) begin
            m_frame <= 1'b1;
            m_t0    <= cyc + 1;
            m_word  <= conv(sample_i);
            exp_q.push_back(conv(sample_i));
            n_acc   <= n_acc + 1;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int   d;
        logic e_rdy, e_sclk, e_cs, e_sdo, e_busy, e_done;
        if (started) begin
            d = cyc - m_t0 + 1;
            e_rdy = 1'b1; e_sclk = 1'b0; e_cs = 1'b1; e_sdo = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (m_frame && d <= FRAME) begin
                e_rdy  = 1'b0;
                e_cs   = 1'b0;
                e_busy = 1'b1;
                e_sclk = 1'(((d - 1) / CLK_DIV) % 2);
                e_sdo  = m_word[N - (d - 1) / (2 * CLK_DIV)];
            end else if (m_frame && d <= FRAME + GAP) begin
                e_rdy  = 1'b0;
                e_busy = 1'b1;
            end else if (m_frame && d == DONE_D) begin
                e_done = 1'b1;
            end
            chk("ready_o", 32'(ready_o), 32'(e_rdy));
            chk("sclk_o",  32'(sclk_o),  32'(e_sclk));
            chk("cs_n_o",  32'(cs_n_o),  32'(e_cs));
            chk("sdo_o",   32'(sdo_o),   32'(e_sdo));
            chk("busy_o",  32'(busy_o),  32'(e_busy));
            chk("done_o",  32'(done_o),  32'(e_done));
        end
    end

    // DAC side: sample sdo on each sclk rise while selected, deliver the word when cs_n releases.
    logic [15:0] cap = '0;
    logic [15:0] caps[$];
    int          nbits = 0, low_run = 0, high_run = 0, low_last = 0, high_last = 0, n_done = 0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;

    always @(negedge clk) begin
        if (started) begin
            if (done_o === 1'b1) n_done++;
            if (!cs_n_o && sclk_o && !prev_sclk) begin
                cap = {cap[14:0], sdo_o};
                nbits++;
            end
            if (cs_n_o && !prev_cs) begin
                low_last = low_run;
                if (nbits == W && !rst_seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dac_capture: got %h with no word pending", cap);
                    end else begin
                        chk("dac_capture", 32'(cap), 32'(exp_q.pop_front()));
                    end
                    caps.push_back(cap);
                end
                nbits = 0;
                cap = '0;
            end
            if (!cs_n_o && prev_cs) high_last = high_run;
            if (cs_n_o) begin high_run++; low_run = 0; end
            else begin low_run++; high_run = 0; end
            prev_sclk = sclk_o;
            prev_cs = cs_n_o;
        end
    end

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_idle() && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout("wait_idle");
    endtask

    task automatic send(input logic [15:0] w);
        wait_idle();
        valid_i = 1'b1;
        sample_i = w;
        @(posedge clk); #1;
        valid_i = 1'b0;
        sample_i = 16'($urandom);
    endtask

    initial begin
        int n, target, nd;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_cs_n",  32'(cs_n_o),  1);
        chk("rst_sclk",  32'(sclk_o),  0);
        chk("rst_sdo",   32'(sdo_o),   0);
        chk("rst_done",  32'(done_o),  0);
        @(posedge clk); #1;

        // single frame: word, cs_n low length and done latency
        send(16'h028B);
        wait_idle();
        @(negedge clk);
        chk("t2_done_at_67", 32'(done_o), 1);
        chk("t2_cs_low_len", 32'(low_last), 64);
        chk("t2_word", 32'(caps[$]), 32'(E_028B));
        @(posedge clk); #1;

        // format words including negative values and negative zero
        send(16'h80D2);
        wait_idle();
        @(negedge clk);
        chk("t3_word_80D2", 32'(caps[$]), 32'(E_80D2));
        @(posedge clk); #1;
        send(16'h8000);
        wait_idle();
        @(negedge clk);
        chk("t3_word_8000", 32'(caps[$]), 32'(E_8000));
        @(posedge clk); #1;

        // back-to-back with valid held: second word accepted in the done cycle
        valid_i = 1'b1;
        sample_i = 16'h028B;
        @(posedge clk); #1;
        sample_i = 16'h02A3;
        target = n_acc + 1;
        n = 0;
        while (n_acc < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout("t4_second_accept");
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        // gap cycles plus the done cycle in which the next word is taken
        chk("t4_cs_high_len", 32'(high_last), 32'(GAP + 1));
        @(posedge clk); #1;
        wait_idle();
        @(negedge clk);
        chk("t4_first",  32'(caps[$-1]), 32'(E_028B));
        chk("t4_second", 32'(caps[$]),   32'(E_02A3));
        @(posedge clk); #1;

        // valid pulse mid-frame is ignored
        nd = n_done;
        send(16'h1234);
        repeat (20) @(posedge clk);
        #1 valid_i = 1'b1;
        sample_i = 16'hFFFF;
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("t5_word", 32'(caps[$]), 32'(E_1234));
        chk("t5_one_done", 32'(n_done - nd), 1);
        chk("t5_no_restart", 32'(cs_n_o), 1);
        @(posedge clk); #1;

        // reset mid-frame aborts without done, next frame is clean
        send(16'h5A5A);
        n = 0;
        while (nbits != 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("t6_bit7");
        nd = n_done;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_cs_n", 32'(cs_n_o), 1);
        chk("t6_sclk", 32'(sclk_o), 0);
        chk("t6_ready", 32'(ready_o), 1);
        repeat (80) @(negedge clk);
        chk("t6_no_done", 32'(n_done - nd), 0);
        @(posedge clk); #1;
        send(16'h0F0F);
        wait_idle();
        @(negedge clk);
        chk("t6_next_word", 32'(caps[$]), 32'(E_0F0F));
        @(posedge clk); #1;

        // random traffic with stray valids and occasional resets
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            send(16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 70)) @(posedge clk);
                #1 valid_i = 1'b1;
                sample_i = 16'($urandom);
                @(posedge clk); #1;
                valid_i = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(2, 70)) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            wait_idle();
        end
        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
